// File: rtl/srl_fifo.sv
// srl_fifo: first-word-fall-through FIFO on an addressable shift register.
// New words enter at index 0 and everything already stored moves up one
// slot; the occupancy counter selects the read tap, so the oldest word is
// always at storage[COUNT-1] and appears on DOUT with no read latency.
// Storage carries no reset, so it packs into cascaded SRL primitives.
module srl_fifo #(
    parameter int   WIDTH           = 8,
    parameter int   DEPTH           = 32,
    parameter int   AFULL_THR       = DEPTH - 2,
    parameter int   AEMPTY_THR      = 2,
    parameter logic IS_CLK_INVERTED = 1'b0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WR_EN,
    input  logic [WIDTH-1:0]             DIN,
    input  logic                         RD_EN,
    output logic [WIDTH-1:0]             DOUT,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ALMOST_EMPTY,
    output logic                         ALMOST_FULL,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         OVF,
    output logic                         UDF
);

    // Counter width covers 0..DEPTH inclusive; the tap address covers
    // 0..DEPTH-1.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks.
    // ------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "srl_fifo: WIDTH must be in 1..64");
    end
    if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "srl_fifo: DEPTH must be a power of two in 2..128");
    end
    if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
        $fatal(1, "srl_fifo: AFULL_THR must be in 1..DEPTH");
    end
    if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "srl_fifo: AEMPTY_THR must be in 0..DEPTH-1");
    end

    // ------------------------------------------------------------------
    // Handshake: WR_EN is a write request qualified by "not FULL, or a read
    // is popping in the same cycle"; RD_EN pops the word currently on DOUT
    // and is qualified by "not EMPTY". An unqualified request is dropped
    // and recorded in the sticky OVF/UDF flags instead of stalling.
    // ------------------------------------------------------------------

    // Power-up contents are zero; there is deliberately no reset on storage.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic            clk_int;
    logic            wr_ok;
    logic            rd_ok;
    logic [CW-1:0]   count_nxt;
    logic            empty_nxt;
    logic            full_nxt;
    logic            aempty_nxt;
    logic            afull_nxt;
    logic            ovf_nxt;
    logic            udf_nxt;
    logic [AW-1:0]   tap;

    // Edge selection: an inverted clock puts every register on negedge CLK.
    assign clk_int = CLK ^ IS_CLK_INVERTED;

    // Effective operations and next-state values for counter and flags.
    always_comb begin
        wr_ok      = WR_EN & (~FULL | RD_EN) & ~RST;
        rd_ok      = RD_EN & ~EMPTY & ~RST;
        count_nxt  = COUNT;
        ovf_nxt    = OVF;
        udf_nxt    = UDF;
        if (RST) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            udf_nxt   = 1'b0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count_nxt = COUNT + CW'(1);
                2'b01:   count_nxt = COUNT - CW'(1);
                default: count_nxt = COUNT;
            endcase
            // A write at FULL is only lost when no read frees a slot.
            if (WR_EN & FULL & ~RD_EN) begin
                ovf_nxt = 1'b1;
            end
            if (RD_EN & EMPTY) begin
                udf_nxt = 1'b1;
            end
        end
        // Flags derive from the next count so they line up with COUNT.
        empty_nxt  = (count_nxt == '0);
        full_nxt   = (count_nxt == DEPTH_C);
        afull_nxt  = (count_nxt >= AFULL_C);
        aempty_nxt = (count_nxt <= AEMPTY_C);
    end

    // Shift register: insert at index 0, move every entry up by one.
    always_ff @(posedge clk_int) begin
        if (wr_ok) begin
            mem[0] <= DIN;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Occupancy counter, registered status flags and sticky error flags.
    always_ff @(posedge clk_int) begin
        COUNT        <= count_nxt;
        EMPTY        <= empty_nxt;
        FULL         <= full_nxt;
        ALMOST_EMPTY <= aempty_nxt;
        ALMOST_FULL  <= afull_nxt;
        OVF          <= ovf_nxt;
        UDF          <= udf_nxt;
    end

    // Read tap: oldest word sits at COUNT-1; when empty, show index 0.
    always_comb begin
        if (COUNT == '0) begin
            tap = '0;
        end else begin
            tap = AW'(COUNT - CW'(1));
        end
        DOUT = mem[tap];
    end

endmodule
